// File: rtl/placar_pkg.sv
// rtl/placar_pkg.sv - shared types and constants for the scoreboard controller
package placar_pkg;

    localparam int LARGURA_PLACAR = 7;

    localparam logic [1:0] PONTO_A = 2'd1;
    localparam logic [1:0] PONTO_B = 2'd2;
    localparam logic [1:0] PONTO_C = 2'd3;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        VERIFICA,
        ESPERA_SOLTA
    } estado_t;

    // Highest pressed button wins when several are held together.
    function automatic logic [1:0] valor_pontos(input logic a, input logic b, input logic c);
        if (c)      return PONTO_C;
        else if (b) return PONTO_B;
        else if (a) return PONTO_A;
        else        return 2'd0;
    endfunction

endpackage

// File: rtl/debounce_botao.sv
// rtl/debounce_botao.sv - two-flop synchronizer plus stability counter for one button
module debounce_botao #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bruto,
    output logic nivel
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sinc1;
    logic          sinc2;
    logic [CW-1:0] cont;

    // The level flips only after DEBOUNCE_CYCLES consecutive samples that disagree with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sinc1 <= 1'b0;
            sinc2 <= 1'b0;
            cont  <= '0;
            nivel <= 1'b0;
        end else begin
            sinc1 <= bruto;
            sinc2 <= sinc1;
            if (sinc2 == nivel) begin
                cont <= '0;
            end else if (cont == CW'(DEBOUNCE_CYCLES - 1)) begin
                nivel <= sinc2;
                cont  <= '0;
            end else begin
                cont <= cont + CW'(1);
            end
        end
    end

endmodule

// File: rtl/controlador_placar.sv
// rtl/controlador_placar.sv - sequences the shared adder/subtractor between the two team scores
module controlador_placar
    import placar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int LIMITE          = 99
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      btn_a,
    input  logic                      btn_b,
    input  logic                      btn_c,
    input  logic                      chave_neg,
    input  logic                      sel_time,
    input  logic                      zerar,
    output logic [LARGURA_PLACAR-1:0] ops_a,
    output logic [1:0]                ops_b,
    output logic                      ops_sub,
    input  logic [LARGURA_PLACAR-1:0] ops_s,
    input  logic                      ops_cout,
    output logic [LARGURA_PLACAR-1:0] placar_t0,
    output logic [LARGURA_PLACAR-1:0] placar_t1,
    output logic                      invalido,
    output logic                      alerta,
    output logic                      ocupado
);

    localparam logic [LARGURA_PLACAR-1:0] LIMITE_P = LARGURA_PLACAR'(LIMITE);

    logic [2:0] nivel;
    logic       qualquer;
    logic       qualquer_ant;
    logic       evento;
    logic       aceito;
    logic       time_lat;
    estado_t    estado;

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bruto (btn_a),
        .nivel (nivel[0])
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bruto (btn_b),
        .nivel (nivel[1])
    );

    debounce_botao #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_c (
        .clk   (clk),
        .rst_n (rst_n),
        .bruto (btn_c),
        .nivel (nivel[2])
    );

    assign qualquer = |nivel;
    assign evento   = qualquer & ~qualquer_ant & (estado == OCIOSO);

    // Carry out means "no overflow" for add is 0, "no borrow" for subtract is 1.
    assign aceito  = ops_sub ? ops_cout : ~ops_cout;
    assign alerta  = (placar_t0 > LIMITE_P) | (placar_t1 > LIMITE_P);
    assign ocupado = (estado != OCIOSO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado       <= OCIOSO;
            qualquer_ant <= 1'b0;
            time_lat     <= 1'b0;
            ops_a        <= '0;
            ops_b        <= '0;
            ops_sub      <= 1'b0;
            placar_t0    <= '0;
            placar_t1    <= '0;
            invalido     <= 1'b0;
        end else begin
            qualquer_ant <= qualquer;
            if (zerar) begin
                estado    <= OCIOSO;
                time_lat  <= 1'b0;
                ops_a     <= '0;
                ops_b     <= '0;
                ops_sub   <= 1'b0;
                placar_t0 <= '0;
                placar_t1 <= '0;
                invalido  <= 1'b0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (evento) begin
                            // Operands are registered here so they are stable through CALCULA and VERIFICA.
                            ops_a    <= sel_time ? placar_t1 : placar_t0;
                            ops_b    <= valor_pontos(nivel[0], nivel[1], nivel[2]);
                            ops_sub  <= chave_neg;
                            time_lat <= sel_time;
                            estado   <= CALCULA;
                        end
                    end
                    CALCULA: begin
                        estado <= VERIFICA;
                    end
                    VERIFICA: begin
                        if (aceito) begin
                            if (time_lat) placar_t1 <= ops_s;
                            else          placar_t0 <= ops_s;
                            invalido <= 1'b0;
                        end else begin
                            invalido <= 1'b1;
                        end
                        ops_a   <= '0;
                        ops_b   <= '0;
                        ops_sub <= 1'b0;
                        estado  <= ESPERA_SOLTA;
                    end
                    ESPERA_SOLTA: begin
                        if (!qualquer) estado <= OCIOSO;
                    end
                    default: estado <= OCIOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_controlador_placar.sv
// tb/tb_controlador_placar.sv - self-checking bench for controlador_placar
module tb_controlador_placar;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_a, btn_b, btn_c;
    logic       chave_neg, sel_time, zerar;
    logic [6:0] ops_a;
    logic [1:0] ops_b;
    logic       ops_sub;
    logic [6:0] ops_s;
    logic       ops_cout;
    logic [6:0] placar_t0, placar_t1;
    logic       invalido, alerta, ocupado;

    always #5 clk = ~clk;

    controlador_placar #(.DEBOUNCE_CYCLES(4), .LIMITE(99)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_a     (btn_a),
        .btn_b     (btn_b),
        .btn_c     (btn_c),
        .chave_neg (chave_neg),
        .sel_time  (sel_time),
        .zerar     (zerar),
        .ops_a     (ops_a),
        .ops_b     (ops_b),
        .ops_sub   (ops_sub),
        .ops_s     (ops_s),
        .ops_cout  (ops_cout),
        .placar_t0 (placar_t0),
        .placar_t1 (placar_t1),
        .invalido  (invalido),
        .alerta    (alerta),
        .ocupado   (ocupado)
    );

    // External 7-bit adder/subtractor: A + B, or A + ~B + 1 with B zero-extended.
    logic [7:0] soma;
    always_comb begin
        soma = 8'd0;
        if (ops_sub) soma = {1'b0, ops_a} + {1'b0, ~{5'b0, ops_b}} + 8'd1;
        else         soma = {1'b0, ops_a} + {6'b0, ops_b};
    end
    assign ops_s    = soma[6:0];
    assign ops_cout = soma[7];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nome, input int atual, input int esperado);
        n_cmp++;
        if (atual != esperado) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nome, atual, esperado);
        end
    endtask

    // Reference model: plain integer scores with a 0..127 legality window.
    int m_s[2];
    int m_inv;

    task automatic model_apply(input logic [2:0] m, input logic neg, input logic team);
        int p;
        int r;
        p = m[2] ? 3 : (m[1] ? 2 : (m[0] ? 1 : 0));
        r = neg ? m_s[team] - p : m_s[team] + p;
        if (r < 0 || r > 127) m_inv = 1;
        else begin
            m_s[team] = r;
            m_inv     = 0;
        end
    endtask

    task automatic model_clear();
        m_s[0] = 0;
        m_s[1] = 0;
        m_inv  = 0;
    endtask

    task automatic check_model(input string nome);
        chk({nome, "_t0"}, placar_t0, m_s[0]);
        chk({nome, "_t1"}, placar_t1, m_s[1]);
        chk({nome, "_inv"}, invalido, m_inv);
        chk({nome, "_alerta"}, alerta, int'(m_s[0] > 99 || m_s[1] > 99));
    endtask

    int         mudancas = 0;
    logic [6:0] p0 = '0, p1 = '0;
    always @(negedge clk) begin
        if (placar_t0 !== p0 || placar_t1 !== p1) mudancas++;
        p0 = placar_t0;
        p1 = placar_t1;
    end

    task automatic wait_idle();
        int t;
        t = 0;
        repeat (10) @(negedge clk);
        while (ocupado && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", ocupado, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_press(input logic [2:0] m, input logic neg, input logic team,
                            input int hold, input bit flip);
        @(negedge clk);
        chave_neg = neg;
        sel_time  = team;
        {btn_c, btn_b, btn_a} = m;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (flip && i == 8) begin
                chave_neg = ~neg;
                sel_time  = ~team;
            end
        end
        {btn_c, btn_b, btn_a} = 3'b000;
        wait_idle();
        model_apply(m, neg, team);
    endtask

    typedef struct {
        logic [2:0] botoes;
        logic       neg;
        logic       equipe;
        int         t0;
        int         t1;
        int         inv;
        int         al;
    } vetor_t;

    vetor_t tabela [7];

    initial begin
        int pt0, pt1, oc;
        logic [2:0] m;
        logic neg, team;

        tabela[0] = '{3'b100, 1'b0, 1'b0, 3, 0, 0, 0};
        tabela[1] = '{3'b010, 1'b0, 1'b1, 3, 2, 0, 0};
        tabela[2] = '{3'b100, 1'b1, 1'b1, 3, 2, 1, 0};
        tabela[3] = '{3'b010, 1'b1, 1'b1, 3, 0, 0, 0};
        tabela[4] = '{3'b101, 1'b0, 1'b0, 6, 0, 0, 0};
        tabela[5] = '{3'b001, 1'b1, 1'b1, 6, 0, 1, 0};
        tabela[6] = '{3'b011, 1'b0, 1'b1, 6, 2, 0, 0};

        rst_n = 1'b0;
        {btn_c, btn_b, btn_a} = 3'b000;
        chave_neg = 1'b0;
        sel_time  = 1'b0;
        zerar     = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        chk("rst_t0", placar_t0, 0);
        chk("rst_t1", placar_t1, 0);
        chk("rst_inv", invalido, 0);
        chk("rst_alerta", alerta, 0);
        chk("rst_ocupado", ocupado, 0);
        chk("rst_ops", {ops_a, ops_b, ops_sub}, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        pt0 = 0;
        pt1 = 0;
        for (int i = 0; i < 7; i++) begin
            mudancas = 0;
            do_press(tabela[i].botoes, tabela[i].neg, tabela[i].equipe, 40, 1'b0);
            chk($sformatf("vec%0d_t0", i), placar_t0, tabela[i].t0);
            chk($sformatf("vec%0d_t1", i), placar_t1, tabela[i].t1);
            chk($sformatf("vec%0d_inv", i), invalido, tabela[i].inv);
            chk($sformatf("vec%0d_alerta", i), alerta, tabela[i].al);
            chk($sformatf("vec%0d_updates", i), mudancas,
                int'(tabela[i].t0 != pt0) + int'(tabela[i].t1 != pt1));
            pt0 = tabela[i].t0;
            pt1 = tabela[i].t1;
        end

        while (m_s[0] < 96) do_press(3'b100, 1'b0, 1'b0, 12, 1'b0);
        do_press(3'b010, 1'b0, 1'b0, 12, 1'b0);
        chk("climb_98", placar_t0, 98);
        do_press(3'b010, 1'b0, 1'b0, 12, 1'b0);
        chk("t0_100", placar_t0, 100);
        chk("alerta_100", alerta, 1);
        do_press(3'b001, 1'b1, 1'b0, 12, 1'b0);
        chk("t0_99", placar_t0, 99);
        chk("alerta_99", alerta, 0);
        while (m_s[0] < 126) do_press(3'b100, 1'b0, 1'b0, 12, 1'b0);
        chk("climb_126", placar_t0, 126);
        do_press(3'b010, 1'b0, 1'b0, 12, 1'b0);
        chk("carry_t0", placar_t0, 126);
        chk("carry_inv", invalido, 1);
        do_press(3'b001, 1'b0, 1'b0, 12, 1'b0);
        chk("t0_127", placar_t0, 127);
        chk("t0_127_inv", invalido, 0);
        do_press(3'b001, 1'b0, 1'b0, 12, 1'b0);
        chk("over_127", placar_t0, 127);
        chk("over_127_inv", invalido, 1);
        check_model("boundary");

        // Exact latency: raw press to score is 2 + DEBOUNCE_CYCLES + 3 edges.
        @(negedge clk);
        chave_neg = 1'b1;
        sel_time  = 1'b0;
        btn_c     = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("lat_ocupado_e6", ocupado, 0);
        @(posedge clk);
        @(negedge clk);
        chk("lat_ocupado_e7", ocupado, 1);
        chk("lat_ops_a", ops_a, 127);
        chk("lat_ops_b", ops_b, 3);
        chk("lat_ops_sub", ops_sub, 1);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e8_t0", placar_t0, 127);
        @(posedge clk);
        @(negedge clk);
        chk("lat_e9_t0", placar_t0, 124);
        chk("lat_ops_clear", {ops_a, ops_b, ops_sub}, 0);
        btn_c = 1'b0;
        wait_idle();
        model_apply(3'b100, 1'b1, 1'b0);
        check_model("latency");

        // Reset while in VERIFICA must abort with no partial commit.
        @(negedge clk);
        chave_neg = 1'b0;
        sel_time  = 1'b1;
        btn_a     = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("vrf_ocupado", ocupado, 1);
        rst_n = 1'b0;
        btn_a = 1'b0;
        #1;
        chk("arst_t0", placar_t0, 0);
        chk("arst_t1", placar_t1, 0);
        chk("arst_inv", invalido, 0);
        chk("arst_alerta", alerta, 0);
        chk("arst_ocupado", ocupado, 0);
        chk("arst_ops", {ops_a, ops_b, ops_sub}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        repeat (10) @(negedge clk);
        check_model("post_reset");

        // zerar in the commit cycle wins over the commit.
        do_press(3'b100, 1'b0, 1'b0, 12, 1'b0);
        do_press(3'b100, 1'b1, 1'b1, 12, 1'b0);
        chk("pre_zerar_inv", invalido, 1);
        @(negedge clk);
        chave_neg = 1'b0;
        sel_time  = 1'b1;
        btn_a     = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        zerar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        zerar = 1'b0;
        chk("zerar_t0", placar_t0, 0);
        chk("zerar_t1", placar_t1, 0);
        chk("zerar_inv", invalido, 0);
        repeat (5) @(negedge clk);
        btn_a = 1'b0;
        wait_idle();
        model_clear();
        check_model("post_zerar");

        // A 2-cycle glitch never reaches the debounced level.
        @(negedge clk);
        btn_a = 1'b1;
        repeat (2) @(negedge clk);
        btn_a = 1'b0;
        oc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (ocupado) oc = 1;
        end
        chk("glitch_ocupado", oc, 0);
        check_model("glitch");

        for (int i = 0; i < 25; i++) begin
            m    = 3'($urandom_range(1, 7));
            neg  = 1'($urandom_range(0, 1));
            team = 1'($urandom_range(0, 1));
            do_press(m, neg, team, $urandom_range(10, 30), 1'b1);
            check_model($sformatf("rnd%0d", i));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk);
                zerar = 1'b1;
                @(negedge clk);
                zerar = 1'b0;
                model_clear();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
